alu_frame_ctrl: RTL and testbench

Framed command controller for the UART-attached 8-bit ALU. It sits between the UART receiver/transmitter and the ALU, and replaces loose byte sequencing with checked frames. Each frame is SYNC, OP, A, B, CHK. The block hunts for the sync byte, verifies the checksum and opcode, and times out stalled frames. It drives the ALU only for valid frames, waits a configurable latency, and replies with a two-byte response: status, then payload.

---
 rtl/alu_frame_if.sv | 14 +
 rtl/alu_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_frame_if.sv
// UART-side bus of the framed ALU controller.
// rx_valid is a one-cycle strobe qualifying rx_data; tx_start is a one-cycle request
// qualifying tx_data, and tx_busy (from the transmitter) rises the cycle after
// tx_start and falls once the byte has gone out.
interface alu_frame_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (output rx_data, rx_valid, tx_busy, input tx_data, tx_start);
  modport slave  (input rx_data, rx_valid, tx_busy, output tx_data, tx_start);
endinterface

// File: rtl/alu_frame_ctrl.sv
// Framed command controller: hunts SYNC, checks OP/A/B/CHK frames, drives the ALU
// for valid frames and answers every frame with a status byte and a payload byte.
module alu_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         ALU_LAT        = 1
) (
  input  logic        clk,
  input  logic        rst,
  alu_frame_if.slave  uart,
  input  logic [7:0]  alu_result,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        busy,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic [3:0]  dbg_state
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(ALU_LAT + 1);

  typedef enum logic [3:0] {
    HUNT, GET_OP, GET_A, GET_B, GET_CHK, EXEC,
    SEND_STAT, WAIT_STAT, SEND_RES, WAIT_RES
  } state_t;

  state_t        state;
  logic [7:0]    op_q, a_q, b_q, status_q, payload_q;
  logic [IW-1:0] idle_cnt;
  logic [LW-1:0] exec_cnt;
  logic          seen_busy;
  logic [7:0]    err_next;

  assign err_next  = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
  assign busy      = (state != HUNT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      status_q      <= '0;
      payload_q     <= '0;
      idle_cnt      <= '0;
      exec_cnt      <= '0;
      seen_busy     <= 1'b0;
      uart.tx_data  <= '0;
      uart.tx_start <= 1'b0;
      alu_A         <= '0;
      alu_B         <= '0;
      alu_op        <= '0;
      frame_err     <= 1'b0;
      err_count     <= '0;
    end else begin
      uart.tx_start <= 1'b0;
      frame_err     <= 1'b0;
      case (state)
        HUNT: begin
          if (uart.rx_valid && uart.rx_data == SYNC_BYTE) begin
            idle_cnt <= '0;
            state    <= GET_OP;
          end
        end
        GET_OP, GET_A, GET_B, GET_CHK: begin
          // An arriving byte always beats a timeout reached in the same cycle.
          if (uart.rx_valid) begin
            idle_cnt <= '0;
            case (state)
              GET_OP: begin op_q <= uart.rx_data; state <= GET_A;   end
              GET_A:  begin a_q  <= uart.rx_data; state <= GET_B;   end
              GET_B:  begin b_q  <= uart.rx_data; state <= GET_CHK; end
              default: begin
                if (uart.rx_data != (op_q ^ a_q ^ b_q)) begin
                  status_q  <= 8'hE1;
                  payload_q <= 8'h00;
                  frame_err <= 1'b1;
                  err_count <= err_next;
                  state     <= SEND_STAT;
                end else if (op_q[7:3] != 5'd0) begin
                  status_q  <= 8'hE2;
                  payload_q <= 8'h00;
                  frame_err <= 1'b1;
                  err_count <= err_next;
                  state     <= SEND_STAT;
                end else begin
                  alu_op   <= op_q[2:0];
                  alu_A    <= a_q;
                  alu_B    <= b_q;
                  exec_cnt <= '0;
                  state    <= EXEC;
                end
              end
            endcase
          end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            err_count <= err_next;
            state     <= HUNT;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        EXEC: begin
          if (exec_cnt == LW'(ALU_LAT - 1)) begin
            payload_q <= alu_result;
            status_q  <= 8'h00;
            state     <= SEND_STAT;
          end else begin
            exec_cnt <= exec_cnt + LW'(1);
          end
        end
        SEND_STAT: begin
          if (!uart.tx_busy) begin
            uart.tx_data  <= status_q;
            uart.tx_start <= 1'b1;
            seen_busy     <= 1'b0;
            state         <= WAIT_STAT;
          end
        end
        WAIT_STAT: begin
          // Only a busy->idle transition of the transmitter completes the byte.
          if (uart.tx_busy)   seen_busy <= 1'b1;
          else if (seen_busy) state     <= SEND_RES;
        end
        SEND_RES: begin
          if (!uart.tx_busy) begin
            uart.tx_data  <= payload_q;
            uart.tx_start <= 1'b1;
            seen_busy     <= 1'b0;
            state         <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (uart.tx_busy)   seen_busy <= 1'b1;
          else if (seen_busy) state     <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl with a small ALU model and a UART transmitter model.
module tb_alu_frame_ctrl;
  localparam logic [3:0] S_HUNT = 4'd0, S_GET_B = 4'd3, S_EXEC = 4'd5,
                         S_WAIT_STAT = 4'd7, S_WAIT_RES = 4'd9;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_result, alu_a, alu_b, err_count;
  logic [2:0] alu_op;
  logic       busy, frame_err;
  logic [3:0] dbg_state;

  alu_frame_if bus();

  alu_frame_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(20), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .uart(bus), .alu_result(alu_result),
    .alu_A(alu_a), .alu_B(alu_b), .alu_op(alu_op), .busy(busy),
    .frame_err(frame_err), .err_count(err_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int tx_count     = 0;
  int unstable_cnt = 0;
  int busy_len     = 3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model and scoreboard: every tx_start is matched against exp_q.
  initial begin : tx_model
    logic [7:0] cur_byte;
    int  busy_left;
    bit  pending;
    bus.tx_busy = 1'b0;
    cur_byte = 8'h00;
    busy_left = 0;
    pending = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_busy) begin
        if (bus.tx_data !== cur_byte) unstable_cnt++;
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end
      if (pending) begin
        bus.tx_busy = 1'b1;
        busy_left = busy_len;
        pending = 1'b0;
      end
      if (bus.tx_start === 1'b1) begin
        pending = 1'b1;
        cur_byte = bus.tx_data;
        tx_count++;
        if (exp_q.size() == 0) check("tx_extra_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(a);
    send_byte(b);
    send_byte(chk);
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (dbg_state !== s && n < 1000) begin
      tick(1);
      n++;
    end
    check(tag, {28'd0, dbg_state}, {28'd0, s});
  endtask

  int start_cnt;

  initial begin
    rst = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    tick(3);
    check("rst_tx_data", {24'd0, bus.tx_data}, 0);
    check("rst_tx_start", {31'd0, bus.tx_start}, 0);
    check("rst_alu_a", {24'd0, alu_a}, 0);
    check("rst_alu_b", {24'd0, alu_b}, 0);
    check("rst_alu_op", {29'd0, alu_op}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_err_count", {24'd0, err_count}, 0);
    rst = 1'b0;

    // Garbage then a valid ADD frame: 0x12 + 0x34 = 0x46
    send_byte(8'h11);
    send_byte(8'h22);
    check("garbage_hunt", {28'd0, dbg_state}, {28'd0, S_HUNT});
    check("garbage_no_err", {31'd0, frame_err}, 0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h46);
    send_frame(8'h00, 8'h12, 8'h34, 8'h26);
    check("ok_alu_op", {29'd0, alu_op}, 0);
    check("ok_alu_a", {24'd0, alu_a}, 32'h12);
    check("ok_alu_b", {24'd0, alu_b}, 32'h34);
    check("ok_exec", {28'd0, dbg_state}, {28'd0, S_EXEC});
    check("ok_start_c1", {31'd0, bus.tx_start}, 0);
    tick(1);
    check("ok_start_c2", {31'd0, bus.tx_start}, 0);
    tick(1);
    check("ok_start_c3", {31'd0, bus.tx_start}, 1);
    wait_state(S_HUNT, "ok_done");
    check("ok_err_count", {24'd0, err_count}, 0);

    // Bad checksum
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 8'h12, 8'h34, 8'h27);
    check("chk_frame_err_c1", {31'd0, frame_err}, 1);
    check("chk_err_count", {24'd0, err_count}, 1);
    check("chk_alu_a_kept", {24'd0, alu_a}, 32'h12);
    tick(1);
    check("chk_start_c2", {31'd0, bus.tx_start}, 1);
    check("chk_frame_err_c2", {31'd0, frame_err}, 0);
    wait_state(S_HUNT, "chk_done");

    // Bad opcode
    exp_q.push_back(8'hE2);
    exp_q.push_back(8'h00);
    send_frame(8'h09, 8'h01, 8'h02, 8'h0A);
    check("op_frame_err", {31'd0, frame_err}, 1);
    check("op_err_count", {24'd0, err_count}, 2);
    check("op_alu_op_kept", {29'd0, alu_op}, 0);
    check("op_alu_b_kept", {24'd0, alu_b}, 32'h34);
    wait_state(S_HUNT, "op_done");

    // Timeout after A5 03 and 20 silent cycles
    start_cnt = tx_count;
    send_byte(8'hA5);
    send_byte(8'h03);
    tick(19);
    check("to_not_yet", {31'd0, busy}, 1);
    check("to_no_err_yet", {31'd0, frame_err}, 0);
    tick(1);
    check("to_hunt", {28'd0, dbg_state}, {28'd0, S_HUNT});
    check("to_frame_err", {31'd0, frame_err}, 1);
    check("to_err_count", {24'd0, err_count}, 3);
    tick(1);
    check("to_pulse_end", {31'd0, frame_err}, 0);
    check("to_no_tx", tx_count, start_cnt);
    check("to_alu_a_kept", {24'd0, alu_a}, 32'h12);

    // Normal frame after timeout: SUB 0x50 - 0x20 = 0x30
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h30);
    send_frame(8'h01, 8'h50, 8'h20, 8'h71);
    check("sub_alu_op", {29'd0, alu_op}, 1);
    wait_state(S_HUNT, "sub_done");

    // Byte exactly on the 20th idle cycle is accepted: OR 0xF0 | 0x0F = 0xFF
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h03);
    tick(19);
    send_byte(8'hF0);
    check("edge_state", {28'd0, dbg_state}, {28'd0, S_GET_B});
    check("edge_no_err", {31'd0, frame_err}, 0);
    send_byte(8'h0F);
    send_byte(8'hFC);
    check("edge_err_count", {24'd0, err_count}, 3);
    wait_state(S_HUNT, "edge_done");

    // Slow transmitter; a frame injected during WAIT_RES must be dropped. XOR 3^5 = 6
    busy_len = 50;
    start_cnt = tx_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h06);
    send_frame(8'h04, 8'h03, 8'h05, 8'h02);
    wait_state(S_WAIT_RES, "hs_wait_res");
    send_frame(8'h00, 8'h12, 8'h34, 8'h26);
    wait_state(S_HUNT, "hs_done");
    tick(10);
    check("hs_two_starts", tx_count - start_cnt, 2);
    check("hs_idle_after", {28'd0, dbg_state}, {28'd0, S_HUNT});
    check("hs_alu_a_kept", {24'd0, alu_a}, 32'h03);
    check("hs_tx_stable", unstable_cnt, 0);
    busy_len = 3;
    tick(60);

    // Reset during WAIT_STAT abandons the payload
    busy_len = 10;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 8'h01, 8'h01, 8'h00);
    wait_state(S_WAIT_STAT, "rst_mid_wait");
    start_cnt = tx_count;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rstm_tx_start", {31'd0, bus.tx_start}, 0);
    check("rstm_busy", {31'd0, busy}, 0);
    check("rstm_alu_a", {24'd0, alu_a}, 0);
    check("rstm_alu_op", {29'd0, alu_op}, 0);
    check("rstm_err_count", {24'd0, err_count}, 0);
    check("rstm_tx_data", {24'd0, bus.tx_data}, 0);
    tick(20);
    check("rstm_no_payload", tx_count, start_cnt);
    busy_len = 3;

    // Saturation: 260 bad-checksum frames
    for (int i = 0; i < 260; i++) begin
      exp_q.push_back(8'hE1);
      exp_q.push_back(8'h00);
      send_frame(8'h00, 8'h12, 8'h34, 8'h27);
      if (i == 259) begin
        check("sat_frame_err", {31'd0, frame_err}, 1);
        check("sat_err_count", {24'd0, err_count}, 255);
      end
      wait_state(S_HUNT, "sat_done");
    end
    tick(5);
    check("sat_final", {24'd0, err_count}, 255);
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
